// File: rtl/cam_pkt_gen.sv
// cam_pkt_gen: camera-timing to binarized packet stream for the edge pipeline.
// Each packet is exactly H_ACT*V_ACT one-bit pixels framed by sop/eop. Long lines
// are truncated, short lines/frames are closed with a zero terminator beat, and
// every malformed frame raises a one-cycle frame_err pulse.
module cam_pkt_gen #(
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned SKIP_FRAMES = 10,
    parameter int unsigned THRESH      = 128,
    parameter int unsigned PIX_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             href,
    input  logic             pix_vld,
    input  logic [PIX_W-1:0] pix_in,
    output logic             dout,
    output logic             dout_vld,
    output logic             dout_sop,
    output logic             dout_eop,
    output logic             frame_err
);

    localparam int unsigned CW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int unsigned RW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int unsigned SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;

    localparam logic [CW-1:0]    COL_LAST  = CW'(H_ACT - 1);
    localparam logic [RW-1:0]    ROW_LAST  = RW'(V_ACT - 1);
    localparam logic [SW-1:0]    SKIP_LAST = SW'(SKIP_FRAMES);
    localparam logic [PIX_W-1:0] THR       = PIX_W'(THRESH);

    typedef enum logic [1:0] {
        S_SKIP,
        S_FRAME,
        S_WAIT
    } state_t;

    state_t         state;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [SW-1:0]  skip_cnt;
    logic           pkt_open;
    logic           line_full;   // full line taken, href not yet dropped
    logic           long_seen;   // long-line error already reported for this line
    logic           vsync_d;
    logic           href_d;

    logic vsync_rise;
    logic href_fall;
    logic accept;
    logic col_last;
    logic row_last;
    logic first_pix;

    assign vsync_rise = vsync && !vsync_d;
    assign href_fall  = !href && href_d;
    assign accept     = (state == S_FRAME) && href && pix_vld && !vsync_rise && !line_full;
    assign col_last   = (col == COL_LAST);
    assign row_last   = (row == ROW_LAST);
    assign first_pix  = (col == '0) && (row == '0);

    // Delayed copies of the camera sync inputs for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            vsync_d <= vsync;
            href_d  <= href;
        end
    end

    // Frame FSM, pixel counters and registered packet outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_SKIP;
            col       <= '0;
            row       <= '0;
            skip_cnt  <= '0;
            pkt_open  <= 1'b0;
            line_full <= 1'b0;
            long_seen <= 1'b0;
            dout      <= 1'b0;
            dout_vld  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            dout      <= 1'b0;
            dout_vld  <= 1'b0;
            dout_sop  <= 1'b0;
            dout_eop  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                S_SKIP: begin
                    if (vsync_rise) begin
                        if (skip_cnt == SKIP_LAST) begin
                            state     <= S_FRAME;
                            col       <= '0;
                            row       <= '0;
                            pkt_open  <= 1'b0;
                            line_full <= 1'b0;
                            long_seen <= 1'b0;
                        end else begin
                            skip_cnt <= skip_cnt + 1'b1;
                        end
                    end
                end

                S_FRAME: begin
                    if (vsync_rise) begin
                        // Frame restart; an open packet gets a zero eop terminator
                        if (pkt_open) begin
                            dout_vld  <= 1'b1;
                            dout_eop  <= 1'b1;
                            frame_err <= 1'b1;
                        end
                        col       <= '0;
                        row       <= '0;
                        pkt_open  <= 1'b0;
                        line_full <= 1'b0;
                        long_seen <= 1'b0;
                    end else if (accept) begin
                        dout_vld <= 1'b1;
                        dout     <= (pix_in >= THR);
                        dout_sop <= first_pix;
                        dout_eop <= col_last && row_last;
                        if (first_pix) begin
                            pkt_open <= 1'b1;
                        end
                        if (col_last) begin
                            col       <= '0;
                            line_full <= 1'b1;
                            if (row_last) begin
                                // later assignment wins for the H_ACT=V_ACT=1 case
                                row      <= '0;
                                pkt_open <= 1'b0;
                                state    <= S_WAIT;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            col <= col + 1'b1;
                        end
                    end else if (line_full && href && pix_vld) begin
                        if (!long_seen) begin
                            frame_err <= 1'b1;
                            long_seen <= 1'b1;
                        end
                    end else if (href_fall) begin
                        line_full <= 1'b0;
                        long_seen <= 1'b0;
                        if (!line_full && (col != '0)) begin
                            frame_err <= 1'b1;
                            col       <= '0;
                            if (row_last) begin
                                row   <= '0;
                                state <= S_WAIT;
                                if (pkt_open) begin
                                    dout_vld <= 1'b1;
                                    dout_eop <= 1'b1;
                                    pkt_open <= 1'b0;
                                end
                            end else begin
                                row <= row + 1'b1;
                            end
                        end
                    end
                end

                S_WAIT: begin
                    if (vsync_rise) begin
                        state     <= S_FRAME;
                        col       <= '0;
                        row       <= '0;
                        line_full <= 1'b0;
                        long_seen <= 1'b0;
                    end
                end

                default: state <= S_SKIP;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_pkt_gen.sv
// Directed bench for cam_pkt_gen with H_ACT=4, V_ACT=3, THRESH=128.
// dut skips one frame after reset; dut0 skips none.
module tb_cam_pkt_gen;

    logic       clk;
    logic       rst;
    logic       vsync;
    logic       href;
    logic       pix_vld;
    logic [7:0] pix_in;

    logic dout, dout_vld, dout_sop, dout_eop, frame_err;
    logic z_dout, z_vld, z_sop, z_eop, z_err;

    logic [4:0] o1;
    logic [4:0] o0;
    assign o1 = {dout_vld, dout, dout_sop, dout_eop, frame_err};
    assign o0 = {z_vld, z_dout, z_sop, z_eop, z_err};

    int total = 0;
    int bad   = 0;

    // Pixel table, row-major 3x4, and its hand-derived binarization
    logic [7:0] pv [12] = '{8'd127, 8'd128, 8'd255, 8'd0,
                            8'd200, 8'd50,  8'd130, 8'd10,
                            8'd1,   8'd255, 8'd128, 8'd127};
    bit         dx [12] = '{0, 1, 1, 0,
                            1, 0, 1, 0,
                            0, 1, 1, 0};

    cam_pkt_gen #(
        .H_ACT(4), .V_ACT(3), .SKIP_FRAMES(1), .THRESH(128), .PIX_W(8)
    ) dut (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href), .pix_vld(pix_vld),
        .pix_in(pix_in), .dout(dout), .dout_vld(dout_vld), .dout_sop(dout_sop),
        .dout_eop(dout_eop), .frame_err(frame_err)
    );

    cam_pkt_gen #(
        .H_ACT(4), .V_ACT(3), .SKIP_FRAMES(0), .THRESH(128), .PIX_W(8)
    ) dut0 (
        .clk(clk), .rst(rst), .vsync(vsync), .href(href), .pix_vld(pix_vld),
        .pix_in(pix_in), .dout(z_dout), .dout_vld(z_vld), .dout_sop(z_sop),
        .dout_eop(z_eop), .frame_err(z_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Vector order: {vld, dout, sop, eop, frame_err}
    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%b want=%b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic h, input logic pe, input logic [7:0] p);
        vsync   = v;
        href    = h;
        pix_vld = pe;
        pix_in  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic pixel(input int r, input int c, input bit live, input bit c0, input string tag);
        logic [4:0] e;
        drive(1'b0, 1'b1, 1'b1, pv[r*4+c]);
        e = {1'b1, dx[r*4+c], (r == 0 && c == 0), (r == 2 && c == 3), 1'b0};
        chk($sformatf("%s r%0d c%0d", tag, r, c), o1, live ? e : 5'b00000);
        if (c0) chk($sformatf("%s skip0 r%0d c%0d", tag, r, c), o0, e);
    endtask

    task automatic gap(input string tag);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        chk({tag, " gap"}, o1, 5'b00000);
    endtask

    task automatic line(input int r, input bit live, input bit c0, input string tag);
        for (int c = 0; c < 4; c++) pixel(r, c, live, c0, tag);
        gap(tag);
    endtask

    task automatic vs_pulse(input string tag);
        drive(1'b1, 1'b0, 1'b0, 8'd0);
        chk({tag, " vs hi"}, o1, 5'b00000);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        chk({tag, " vs lo"}, o1, 5'b00000);
    endtask

    task automatic frame(input bit live, input bit c0, input string tag);
        vs_pulse(tag);
        for (int r = 0; r < 3; r++) line(r, live, c0, tag);
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b0; href = 1'b0; pix_vld = 1'b0; pix_in = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dut", o1, 5'b00000);
        chk("reset dut0", o0, 5'b00000);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'd0);

        // Frame 1: dut settles silently, dut0 shows threshold 127/128/255/0
        frame(1'b0, 1'b1, "t1f1");
        // Frame 2: full 12-beat packet on both
        frame(1'b1, 1'b1, "t1f2");

        // Long line: row 1 carries 6 pixels
        vs_pulse("t3");
        line(0, 1'b1, 1'b0, "t3");
        for (int c = 0; c < 4; c++) pixel(1, c, 1'b1, 1'b0, "t3");
        drive(1'b0, 1'b1, 1'b1, 8'd200);
        chk("t3 long px5", o1, 5'b00001);
        drive(1'b0, 1'b1, 1'b1, 8'd200);
        chk("t3 long px6", o1, 5'b00000);
        gap("t3 r1");
        line(2, 1'b1, 1'b0, "t3");

        // Short last line: 2 pixels then href low
        vs_pulse("t4");
        line(0, 1'b1, 1'b0, "t4");
        line(1, 1'b1, 1'b0, "t4");
        pixel(2, 0, 1'b1, 1'b0, "t4");
        pixel(2, 1, 1'b1, 1'b0, "t4");
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t4 terminator", o1, 5'b10011);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t4 after term", o1, 5'b00000);
        line(0, 1'b0, 1'b0, "t4 waiting");

        // Short frame: vsync rises after 5 beats with a pixel present
        vs_pulse("t5");
        line(0, 1'b1, 1'b0, "t5");
        pixel(1, 0, 1'b1, 1'b0, "t5");
        drive(1'b1, 1'b1, 1'b1, 8'd200);
        chk("t5 terminator", o1, 5'b10011);
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        chk("t5 after term", o1, 5'b00000);
        for (int r = 0; r < 3; r++) line(r, 1'b1, 1'b0, "t5 next");

        // Reset mid-packet after 7 beats
        vs_pulse("t6");
        line(0, 1'b1, 1'b0, "t6");
        for (int c = 0; c < 3; c++) pixel(1, c, 1'b1, 1'b0, "t6");
        rst = 1'b1;
        #1;
        chk("t6 async reset", o1, 5'b00000);
        vsync = 1'b0; href = 1'b0; pix_vld = 1'b0; pix_in = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        frame(1'b0, 1'b0, "t6 skipped");
        frame(1'b1, 1'b0, "t6 resumed");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
